// File: rtl/wbu_writeback_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings and FSM states.
package wbu_writeback_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wbu_state_e;

endpackage

// File: rtl/wbu_writeback_if.sv
// Execute-to-writeback handshake, memory response, register-file write and commit signals.
interface wbu_writeback_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_rd_wen;
  logic                  in_is_load;
  logic [2:0]            in_funct3;
  logic [DATA_WIDTH-1:0] in_alu_result;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  commit_valid;
  logic [DATA_WIDTH-1:0] commit_pc;
  logic                  err_timeout;

  // Writeback stage side
  modport slave (
    input  in_valid, in_pc, in_rd, in_rd_wen, in_is_load, in_funct3, in_alu_result,
    input  mem_rvalid, mem_rdata,
    output in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, err_timeout
  );

  // Execute stage / memory / environment side
  modport master (
    output in_valid, in_pc, in_rd, in_rd_wen, in_is_load, in_funct3, in_alu_result,
    output mem_rvalid, mem_rdata,
    input  in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, err_timeout
  );
endinterface

// File: rtl/wbu_writeback_load_ext.sv
// Load data alignment and sign/zero extension from a word-aligned memory read.
module wbu_load_ext
  import wbu_writeback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] ext_data_c
);

  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;

  // Shifting right zero-fills the upper bytes for misaligned accesses.
  always_comb begin
    shamt   = {addr, 3'b000};
    shifted = rdata >> shamt;
    byte_v  = shifted[7:0];
    half_v  = shifted[15:0];
    case (funct3)
      F3_LB:   ext_data_c = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      F3_LH:   ext_data_c = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      F3_LBU:  ext_data_c = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      F3_LHU:  ext_data_c = {{(DATA_WIDTH-16){1'b0}}, half_v};
      default: ext_data_c = shifted;
    endcase
  end

endmodule

// File: rtl/wbu_writeback.sv
// Writeback stage: accepts one retired instruction, waits for load data if needed,
// then performs a single register-file write and commit pulse.
module wbu_writeback
  import wbu_writeback_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rst,
  wbu_writeback_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  wbu_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  rd_wen_q, rd_wen_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;

  logic                  in_ready_q, in_ready_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  commit_valid_q, commit_valid_d;
  logic [DATA_WIDTH-1:0] commit_pc_q, commit_pc_d;
  logic                  err_timeout_q, err_timeout_d;

  logic [DATA_WIDTH-1:0] load_data;

  wbu_load_ext #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_ext (
    .funct3     (funct3_q),
    .addr       (addr_lo_q),
    .rdata      (bus.mem_rdata),
    .ext_data_c (load_data)
  );

  // Next-state, latches and registered outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_d           = pc_q;
    rd_d           = rd_q;
    rd_wen_d       = rd_wen_q;
    funct3_d       = funct3_q;
    addr_lo_d      = addr_lo_q;
    rf_wen_d       = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;
    err_timeout_d  = err_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          pc_d      = bus.in_pc;
          rd_d      = bus.in_rd;
          rd_wen_d  = bus.in_rd_wen;
          funct3_d  = bus.in_funct3;
          addr_lo_d = bus.in_alu_result[1:0];
          cnt_d     = '0;
          if (bus.in_is_load) begin
            state_d = ST_WAIT_MEM;
          end else begin
            state_d        = ST_WRITE;
            rf_wen_d       = bus.in_rd_wen && (bus.in_rd != '0);
            rf_waddr_d     = bus.in_rd;
            rf_wdata_d     = bus.in_alu_result;
            commit_valid_d = 1'b1;
            commit_pc_d    = bus.in_pc;
          end
        end
      end

      ST_WAIT_MEM: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response on the terminal-count cycle still counts as on time.
        if (bus.mem_rvalid) begin
          state_d        = ST_WRITE;
          rf_wen_d       = rd_wen_q && (rd_q != '0);
          rf_waddr_d     = rd_q;
          rf_wdata_d     = load_data;
          commit_valid_d = 1'b1;
          commit_pc_d    = pc_q;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = ST_IDLE;
          err_timeout_d = 1'b1;
          cnt_d         = '0;
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      pc_q           <= '0;
      rd_q           <= '0;
      rd_wen_q       <= 1'b0;
      funct3_q       <= '0;
      addr_lo_q      <= '0;
      in_ready_q     <= 1'b1;
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pc_q           <= pc_d;
      rd_q           <= rd_d;
      rd_wen_q       <= rd_wen_d;
      funct3_q       <= funct3_d;
      addr_lo_q      <= addr_lo_d;
      in_ready_q     <= in_ready_d;
      rf_wen_q       <= rf_wen_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.rf_wen       = rf_wen_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_pc    = commit_pc_q;
  assign bus.err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_wbu_writeback.sv
// Directed plus randomized bench for wbu_writeback against a transaction-level reference.
module tb_wbu_writeback;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  wbu_writeback_if bus ();

  wbu_writeback dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference load extraction: pick the addressed byte/half by arithmetic, then extend.
  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input int unsigned a,
                                          input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] b;
    logic [31:0] h;
    sh = rdata / (32'd1 << (a * 8));
    b  = sh % 32'd256;
    h  = sh % 32'd65536;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return sh;
    endcase
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("ready_wait", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic drive(input bit ld, input logic [4:0] rd, input bit wen, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc);
    bus.in_valid      = 1'b1;
    bus.in_is_load    = ld;
    bus.in_rd         = rd;
    bus.in_rd_wen     = wen;
    bus.in_funct3     = f3;
    bus.in_alu_result = alu;
    bus.in_pc         = pc;
  endtask

  task automatic scramble_inputs();
    bus.in_valid      = 1'b0;
    bus.in_is_load    = 1'($urandom);
    bus.in_rd         = 5'($urandom);
    bus.in_rd_wen     = 1'($urandom);
    bus.in_funct3     = 3'($urandom);
    bus.in_alu_result = $urandom;
    bus.in_pc         = $urandom;
  endtask

  // One full instruction: accept, optional memory wait of dly cycles, write, back to idle.
  task automatic run_instr(input bit ld, input logic [4:0] rd, input bit wen, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] pc,
                           input logic [31:0] rdata, input int dly);
    logic [31:0] exp_d;
    logic        exp_wen;
    exp_wen = wen && (rd != 5'd0);
    exp_d   = ld ? ref_ext(f3, int'(alu[1:0]), rdata) : alu;
    wait_ready();
    drive(ld, rd, wen, f3, alu, pc);
    step();
    scramble_inputs();
    if (ld) begin
      chk("wait_in_ready", 32'(bus.in_ready), 32'd0);
      repeat (dly) step();
      chk("wait_no_commit", 32'(bus.commit_valid), 32'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
      step();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
    end
    chk("wr_rf_wen", 32'(bus.rf_wen), 32'(exp_wen));
    chk("wr_waddr", 32'(bus.rf_waddr), 32'(rd));
    chk("wr_wdata", bus.rf_wdata, exp_d);
    chk("wr_commit", 32'(bus.commit_valid), 32'd1);
    chk("wr_commit_pc", bus.commit_pc, pc);
    chk("wr_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("post_commit", 32'(bus.commit_valid), 32'd0);
    chk("post_rf_wen", 32'(bus.rf_wen), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_waddr_hold", 32'(bus.rf_waddr), 32'(rd));
    chk("post_wdata_hold", bus.rf_wdata, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    scramble_inputs();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_rf_wen", 32'(bus.rf_wen), 32'd0);
    chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    chk("rst_commit", 32'(bus.commit_valid), 32'd0);
    chk("rst_commit_pc", bus.commit_pc, 32'd0);
    chk("rst_err", 32'(bus.err_timeout), 32'd0);

    // Directed cases
    run_instr(1'b0, 5'd5, 1'b1, 3'd0, 32'h1234_5678, 32'h8000_0000, 32'h0, 0);
    run_instr(1'b1, 5'd7, 1'b1, 3'd0, 32'h0000_1003, 32'h8000_0004, 32'h80AB_CDEF, 3);
    run_instr(1'b1, 5'd8, 1'b1, 3'd4, 32'h0000_1003, 32'h8000_0008, 32'h80AB_CDEF, 3);
    run_instr(1'b1, 5'd9, 1'b1, 3'd5, 32'h0000_1002, 32'h8000_000C, 32'h80AB_CDEF, 3);
    run_instr(1'b1, 5'd10, 1'b1, 3'd1, 32'h0000_1002, 32'h8000_0010, 32'h80AB_CDEF, 0);
    run_instr(1'b1, 5'd11, 1'b1, 3'd2, 32'h0000_1001, 32'h8000_0014, 32'h80AB_CDEF, 1);
    run_instr(1'b0, 5'd0, 1'b1, 3'd0, 32'hDEAD_BEEF, 32'h8000_0018, 32'h0, 0);
    run_instr(1'b0, 5'd12, 1'b0, 3'd0, 32'hCAFE_F00D, 32'h8000_001C, 32'h0, 0);

    // Response on the terminal-count cycle is taken, no error
    run_instr(1'b1, 5'd13, 1'b1, 3'd0, 32'h0000_2000, 32'h8000_0020, 32'h0000_007F, 254);
    chk("tc_no_err", 32'(bus.err_timeout), 32'd0);

    // Timeout: no response at all
    wait_ready();
    drive(1'b1, 5'd14, 1'b1, 3'd2, 32'h0000_3000, 32'h8000_0024);
    step();
    scramble_inputs();
    repeat (254) step();
    chk("to_err_before", 32'(bus.err_timeout), 32'd0);
    chk("to_busy_before", 32'(bus.in_ready), 32'd0);
    step();
    chk("to_err", 32'(bus.err_timeout), 32'd1);
    chk("to_in_ready", 32'(bus.in_ready), 32'd1);
    chk("to_rf_wen", 32'(bus.rf_wen), 32'd0);
    chk("to_commit", 32'(bus.commit_valid), 32'd0);
    run_instr(1'b0, 5'd15, 1'b1, 3'd0, 32'h0BAD_F00D, 32'h8000_0028, 32'h0, 0);
    chk("to_err_sticky", 32'(bus.err_timeout), 32'd1);

    // Reset while waiting for memory drops the instruction
    wait_ready();
    drive(1'b1, 5'd16, 1'b1, 3'd2, 32'h0000_4000, 32'h8000_002C);
    step();
    scramble_inputs();
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mr_rf_wen", 32'(bus.rf_wen), 32'd0);
    chk("mr_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("mr_wdata", bus.rf_wdata, 32'd0);
    chk("mr_commit", 32'(bus.commit_valid), 32'd0);
    chk("mr_commit_pc", bus.commit_pc, 32'd0);
    chk("mr_err", 32'(bus.err_timeout), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    step();
    bus.mem_rvalid = 1'b0;
    chk("mr_late_rf_wen", 32'(bus.rf_wen), 32'd0);
    chk("mr_late_commit", 32'(bus.commit_valid), 32'd0);
    step();
    chk("mr_late_commit2", 32'(bus.commit_valid), 32'd0);
    chk("mr_late_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back: in_valid held high across two ALU ops
    wait_ready();
    drive(1'b0, 5'd17, 1'b1, 3'd0, 32'h1111_1111, 32'h8000_0030);
    step();
    chk("b2b_a_wen", 32'(bus.rf_wen), 32'd1);
    chk("b2b_a_waddr", 32'(bus.rf_waddr), 32'd17);
    chk("b2b_a_wdata", bus.rf_wdata, 32'h1111_1111);
    chk("b2b_a_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 5'd18, 1'b1, 3'd0, 32'h2222_2222, 32'h8000_0034);
    step();
    chk("b2b_gap_wen", 32'(bus.rf_wen), 32'd0);
    chk("b2b_gap_commit", 32'(bus.commit_valid), 32'd0);
    chk("b2b_gap_ready", 32'(bus.in_ready), 32'd1);
    step();
    scramble_inputs();
    chk("b2b_b_wen", 32'(bus.rf_wen), 32'd1);
    chk("b2b_b_waddr", 32'(bus.rf_waddr), 32'd18);
    chk("b2b_b_wdata", bus.rf_wdata, 32'h2222_2222);
    chk("b2b_b_pc", bus.commit_pc, 32'h8000_0034);
    step();
    chk("b2b_end_commit", 32'(bus.commit_valid), 32'd0);

    // Randomized instructions with stray mem_rvalid while idle
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      f3 = 3'($urandom);
      bus.mem_rvalid = 1'($urandom);
      bus.mem_rdata  = $urandom;
      step();
      bus.mem_rvalid = 1'b0;
      chk("rnd_idle_commit", 32'(bus.commit_valid), 32'd0);
      run_instr(1'($urandom), 5'($urandom), 1'($urandom), f3, $urandom, $urandom,
                $urandom, int'($urandom_range(0, 6)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
